stage_if: RTL and testbench

Instruction-fetch stage of the five-stage RV32I core. It sits directly upstream of the IF/ID pipeline register and owns the program counter. It serves instructions from a small direct-mapped instruction cache and refills misses through a request/done handshake with the memory controller. Each cycle it presents the current `pc_o`/`inst_o` pair, or raises `stall_req` so that the IF/ID register inserts a bubble.

---
 rtl/stage_if_pkg.sv | 20 ++
 rtl/stage_if_icache.sv | 58 +++++
 rtl/stage_if.sv | 135 +++++++++++++
 tb/tb_stage_if.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_if_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// stage_if_pkg : shared bus widths, cache geometry and IF state encodings
// Rev 1.0
// -----------------------------------------------------------------------------
package stage_if_pkg;

   localparam int c_MEM_ADDR_W     = 32;
   localparam int c_INST_W         = 32;
   localparam int c_ICACHE_INDEX_W = 6;

   typedef logic [c_MEM_ADDR_W-1:0] mem_addr_bus_t;
   typedef logic [c_INST_W-1:0]     inst_bus_t;

   localparam logic [1:0] c_IF_LOOKUP = 2'd0;
   localparam logic [1:0] c_IF_WAIT   = 2'd1;
   localparam logic [1:0] c_IF_DROP   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/stage_if_icache.sv
`default_nettype none
// -----------------------------------------------------------------------------
// stage_if_icache : direct-mapped one-word-per-line instruction cache
// Rev 1.0
// -----------------------------------------------------------------------------
module stage_if_icache
   import stage_if_pkg::*;
#(
   parameter int INDEX_W = c_ICACHE_INDEX_W
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [c_MEM_ADDR_W-1:2]   rd_addr,
   output logic                      rd_hit,
   output logic [c_INST_W-1:0]       rd_data,
   input  logic                      we,
   input  logic [c_MEM_ADDR_W-1:2]   wr_addr,
   input  logic [c_INST_W-1:0]       wr_data
);

   localparam int c_DEPTH = 1 << INDEX_W;
   localparam int c_TAG_W = c_MEM_ADDR_W - INDEX_W - 2;

   logic [c_DEPTH-1:0]  r_valid;
   logic [c_TAG_W-1:0]  r_tag  [c_DEPTH];
   logic [c_INST_W-1:0] r_data [c_DEPTH];

   logic [INDEX_W-1:0]  w_rd_idx;
   logic [c_TAG_W-1:0]  w_rd_tag;
   logic [INDEX_W-1:0]  w_wr_idx;
   logic [c_TAG_W-1:0]  w_wr_tag;

   assign w_rd_idx = rd_addr[INDEX_W+1:2];
   assign w_rd_tag = rd_addr[c_MEM_ADDR_W-1:INDEX_W+2];
   assign w_wr_idx = wr_addr[INDEX_W+1:2];
   assign w_wr_tag = wr_addr[c_MEM_ADDR_W-1:INDEX_W+2];

   // Only the valid bits need reset; tag/data are qualified by them.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_valid <= '0;
      end else if (we) begin
         r_valid[w_wr_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (we) begin
         r_tag[w_wr_idx]  <= w_wr_tag;
         r_data[w_wr_idx] <= wr_data;
      end
   end

   assign rd_hit  = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
   assign rd_data = r_data[w_rd_idx];

endmodule
`default_nettype wire

// File: rtl/stage_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// stage_if : RV32I fetch stage - PC, I-cache lookup and miss refill handshake
// Rev 1.0
// -----------------------------------------------------------------------------
module stage_if
   import stage_if_pkg::*;
#(
   parameter logic [c_MEM_ADDR_W-1:0] RESET_PC       = '0,
   parameter int                      ICACHE_INDEX_W = c_ICACHE_INDEX_W
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      stall_next,
   input  logic                      jump,
   input  logic [c_MEM_ADDR_W-1:0]   jump_target,
   input  logic                      mem_if_done,
   input  logic [c_INST_W-1:0]       mem_if_data,
   output logic                      if_mem_req,
   output logic [c_MEM_ADDR_W-1:0]   if_mem_addr,
   output logic [c_MEM_ADDR_W-1:0]   pc_o,
   output logic [c_INST_W-1:0]       inst_o,
   output logic                      stall_req
);

   logic [1:0]                r_state;
   logic [1:0]                w_state_next;
   logic [c_MEM_ADDR_W-1:0]   r_pc;
   logic [c_MEM_ADDR_W-1:0]   w_pc_next;
   logic [c_MEM_ADDR_W-1:2]   r_req_addr;
   logic [c_MEM_ADDR_W-1:2]   w_req_addr_next;

   logic                      w_cache_hit;
   logic [c_INST_W-1:0]       w_cache_data;
   logic                      w_in_lookup;
   logic                      w_busy;
   logic                      w_hit;
   logic                      w_miss;
   logic                      w_fill;

   stage_if_icache #(
      .INDEX_W (ICACHE_INDEX_W)
   ) u_icache (
      .clock   (clock),
      .reset   (reset),
      .rd_addr (r_pc[c_MEM_ADDR_W-1:2]),
      .rd_hit  (w_cache_hit),
      .rd_data (w_cache_data),
      .we      (w_fill),
      .wr_addr (r_req_addr),
      .wr_data (mem_if_data)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= c_IF_LOOKUP;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_IF_LOOKUP: begin
            if (!jump && !w_cache_hit) begin
               w_state_next = c_IF_WAIT;
            end
         end
         c_IF_WAIT: begin
            if (mem_if_done) begin
               w_state_next = c_IF_LOOKUP;
            end else if (jump) begin
               w_state_next = c_IF_DROP;
            end
         end
         c_IF_DROP: begin
            if (mem_if_done) begin
               w_state_next = c_IF_LOOKUP;
            end
         end
         default: begin
            w_state_next = c_IF_LOOKUP;
         end
      endcase
   end

   // Request is a pure function of state so it cannot glitch on input changes.
   always_comb begin
      w_in_lookup = 1'b0;
      w_busy      = 1'b0;
      case (r_state)
         c_IF_LOOKUP: w_in_lookup = 1'b1;
         c_IF_WAIT:   w_busy      = 1'b1;
         c_IF_DROP:   w_busy      = 1'b1;
         default:     w_in_lookup = 1'b0;
      endcase
   end

   assign w_hit  = w_in_lookup && w_cache_hit;
   assign w_miss = w_in_lookup && !w_cache_hit && !jump;
   // A DROP refill still lands in the cache: the data is correct for req_addr.
   assign w_fill = w_busy && mem_if_done;

   always_comb begin
      w_pc_next       = r_pc;
      w_req_addr_next = r_req_addr;
      if (jump) begin
         w_pc_next = jump_target;
      end else if (w_hit && !stall_next) begin
         w_pc_next = r_pc + 32'd4;
      end
      if (w_miss) begin
         w_req_addr_next = r_pc[c_MEM_ADDR_W-1:2];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_pc       <= RESET_PC;
         r_req_addr <= '0;
      end else begin
         r_pc       <= w_pc_next;
         r_req_addr <= w_req_addr_next;
      end
   end

   assign pc_o        = r_pc;
   assign inst_o      = w_hit ? w_cache_data : '0;
   assign stall_req   = !w_hit;
   assign if_mem_req  = w_busy;
   assign if_mem_addr = {r_req_addr, 2'b00};

endmodule
`default_nettype wire

// File: tb/tb_stage_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_stage_if : vector table, directed corner sequences and random run vs model
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_stage_if;

   localparam logic N = 1'b0;
   localparam logic Y = 1'b1;

   logic        clock = 1'b0;
   logic        reset;
   logic        stall_next;
   logic        jump;
   logic [31:0] jump_target;
   logic        mem_if_done;
   logic [31:0] mem_if_data;
   logic        if_mem_req;
   logic [31:0] if_mem_addr;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic        stall_req;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clock = ~clock;

   stage_if #(
      .RESET_PC       (32'h0),
      .ICACHE_INDEX_W (6)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .stall_next  (stall_next),
      .jump        (jump),
      .jump_target (jump_target),
      .mem_if_done (mem_if_done),
      .mem_if_data (mem_if_data),
      .if_mem_req  (if_mem_req),
      .if_mem_addr (if_mem_addr),
      .pc_o        (pc_o),
      .inst_o      (inst_o),
      .stall_req   (stall_req)
   );

   typedef struct {
      logic        j;
      logic [31:0] tgt;
      logic        sn;
      logic        dn;
      logic [31:0] dat;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
      logic        e_stall;
      logic        e_req;
      logic [31:0] e_addr;
   } vec_t;

   vec_t tbl [19];

   // Reference model: cache as per-index remembered word address, plus a pending flag.
   logic [31:0] m_pc;
   logic [29:0] m_req_word;
   bit          m_pend;
   bit          m_val  [64];
   logic [29:0] m_line [64];
   logic [31:0] m_dat  [64];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic chk_outs(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                           input logic st, input logic rq, input logic [31:0] addr);
      chk({tag, " pc_o"}, pc_o, pc);
      chk({tag, " inst_o"}, inst_o, inst);
      chk({tag, " stall_req"}, {31'b0, stall_req}, {31'b0, st});
      chk({tag, " if_mem_req"}, {31'b0, if_mem_req}, {31'b0, rq});
      if (rq) chk({tag, " if_mem_addr"}, if_mem_addr, addr);
   endtask

   task automatic step(input logic j, input logic [31:0] t, input logic s,
                       input logic d, input logic [31:0] dat);
      jump = j; jump_target = t; stall_next = s; mem_if_done = d; mem_if_data = dat;
      @(posedge clock);
      #1;
      jump = 1'b0; stall_next = 1'b0; mem_if_done = 1'b0;
   endtask

   task automatic idle();
      step(N, 32'h0, N, N, 32'h0);
   endtask

   task automatic jmp(input logic [31:0] t);
      step(Y, t, N, N, 32'h0);
   endtask

   task automatic fill(input logic [31:0] dat);
      step(N, 32'h0, N, Y, dat);
   endtask

   task automatic do_reset();
      reset = 1'b1; jump = 1'b0; jump_target = '0; stall_next = 1'b0;
      mem_if_done = 1'b0; mem_if_data = '0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   function automatic logic [31:0] memfn(input logic [29:0] w);
      return {w, 2'b00} ^ 32'h5A5A_0000 ^ {w[13:0], w[29:12]};
   endfunction

   task automatic random_run(input int cycles);
      int          wait_cnt;
      int          i;
      bit          hit;
      logic        j, s, d;
      logic [31:0] t, dat;
      wait_cnt = 0;
      m_pc = 32'h0; m_req_word = '0; m_pend = 0;
      for (int k = 0; k < 64; k++) m_val[k] = 0;
      for (int c = 0; c < cycles; c++) begin
         i   = int'(m_pc[7:2]);
         hit = !m_pend && m_val[i] && (m_line[i] == m_pc[31:2]);
         chk_outs("rnd", m_pc, hit ? m_dat[i] : 32'h0, !hit, m_pend, {m_req_word, 2'b00});
         j = ($urandom_range(0, 7) == 0);
         t = 32'($urandom_range(0, 255)) << 2;
         if ($urandom_range(0, 39) == 0) t = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
         if ($urandom_range(0, 9) == 0)  t = t | 32'($urandom_range(0, 3));
         s   = ($urandom_range(0, 3) == 0);
         d   = m_pend && (wait_cnt == 0);
         if (m_pend && wait_cnt > 0) wait_cnt--;
         dat = memfn(m_req_word);
         if (!m_pend) begin
            if (j) m_pc = t;
            else if (hit) begin
               if (!s) m_pc = m_pc + 32'd4;
            end else begin
               m_pend     = 1;
               m_req_word = m_pc[31:2];
               wait_cnt   = $urandom_range(0, 4);
            end
         end else begin
            if (d) begin
               m_val[int'(m_req_word[5:0])]  = 1;
               m_line[int'(m_req_word[5:0])] = m_req_word;
               m_dat[int'(m_req_word[5:0])]  = dat;
               m_pend = 0;
            end
            if (j) m_pc = t;
         end
         step(j, t, s, d, dat);
      end
   endtask

   initial begin
      tbl[0]  = '{N, 32'h0,  N, N, 32'h0,          32'h0,  32'h0,          Y, N, 32'h0};
      tbl[1]  = '{N, 32'h0,  N, N, 32'h0,          32'h0,  32'h0,          Y, Y, 32'h0};
      tbl[2]  = '{N, 32'h0,  N, N, 32'h0,          32'h0,  32'h0,          Y, Y, 32'h0};
      tbl[3]  = '{N, 32'h0,  N, N, 32'h0,          32'h0,  32'h0,          Y, Y, 32'h0};
      tbl[4]  = '{N, 32'h0,  N, Y, 32'h0000_0013,  32'h0,  32'h0,          Y, Y, 32'h0};
      tbl[5]  = '{N, 32'h0,  N, N, 32'h0,          32'h0,  32'h0000_0013,  N, N, 32'h0};
      tbl[6]  = '{N, 32'h0,  N, N, 32'h0,          32'h4,  32'h0,          Y, N, 32'h0};
      tbl[7]  = '{N, 32'h0,  N, Y, 32'h0010_0093,  32'h4,  32'h0,          Y, Y, 32'h4};
      tbl[8]  = '{N, 32'h0,  N, N, 32'h0,          32'h4,  32'h0010_0093,  N, N, 32'h0};
      tbl[9]  = '{N, 32'h0,  N, N, 32'h0,          32'h8,  32'h0,          Y, N, 32'h0};
      tbl[10] = '{N, 32'h0,  N, Y, 32'h0020_0113,  32'h8,  32'h0,          Y, Y, 32'h8};
      tbl[11] = '{N, 32'h0,  Y, N, 32'h0,          32'h8,  32'h0020_0113,  N, N, 32'h0};
      tbl[12] = '{N, 32'h0,  Y, N, 32'h0,          32'h8,  32'h0020_0113,  N, N, 32'h0};
      tbl[13] = '{Y, 32'h40, Y, N, 32'h0,          32'h8,  32'h0020_0113,  N, N, 32'h0};
      tbl[14] = '{Y, 32'h0,  N, N, 32'h0,          32'h40, 32'h0,          Y, N, 32'h0};
      tbl[15] = '{N, 32'h0,  N, N, 32'h0,          32'h0,  32'h0000_0013,  N, N, 32'h0};
      tbl[16] = '{N, 32'h0,  N, N, 32'h0,          32'h4,  32'h0010_0093,  N, N, 32'h0};
      tbl[17] = '{N, 32'h0,  N, N, 32'h0,          32'h8,  32'h0020_0113,  N, N, 32'h0};
      tbl[18] = '{N, 32'h0,  N, N, 32'h0,          32'hC,  32'h0,          Y, N, 32'h0};

      do_reset();
      chk("reset if_mem_addr", if_mem_addr, 32'h0);
      for (int i = 0; i < 19; i++) begin
         chk_outs($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_inst, tbl[i].e_stall,
                  tbl[i].e_req, tbl[i].e_addr);
         step(tbl[i].j, tbl[i].tgt, tbl[i].sn, tbl[i].dn, tbl[i].dat);
      end

      // Jump while waiting: refill still fills, but is never presented.
      do_reset();
      chk_outs("drop0", 32'h0, 32'h0, Y, N, 32'h0);
      jmp(32'h10);
      chk_outs("drop1", 32'h10, 32'h0, Y, N, 32'h0);
      idle();
      chk_outs("drop2", 32'h10, 32'h0, Y, Y, 32'h10);
      jmp(32'h100);
      chk_outs("drop3", 32'h100, 32'h0, Y, Y, 32'h10);
      fill(32'h0A0A_0010);
      chk_outs("drop4", 32'h100, 32'h0, Y, N, 32'h0);
      idle();
      chk_outs("drop5", 32'h100, 32'h0, Y, Y, 32'h100);
      fill(32'h0B0B_0100);
      chk_outs("drop6", 32'h100, 32'h0B0B_0100, N, N, 32'h0);
      jmp(32'h10);
      chk_outs("drop7", 32'h10, 32'h0A0A_0010, N, N, 32'h0);

      // Jump coincident with done.
      jmp(32'h180);
      chk_outs("jd0", 32'h180, 32'h0, Y, N, 32'h0);
      idle();
      chk_outs("jd1", 32'h180, 32'h0, Y, Y, 32'h180);
      step(Y, 32'h200, N, Y, 32'h0C0C_0180);
      chk_outs("jd2", 32'h200, 32'h0, Y, N, 32'h0);
      jmp(32'h180);
      chk_outs("jd3", 32'h180, 32'h0C0C_0180, N, N, 32'h0);

      // Aliasing on index 0.
      jmp(32'h0);
      chk_outs("alias0", 32'h0, 32'h0, Y, N, 32'h0);
      idle();
      chk_outs("alias1", 32'h0, 32'h0, Y, Y, 32'h0);
      fill(32'h0000_0013);
      chk_outs("alias2", 32'h0, 32'h0000_0013, N, N, 32'h0);
      jmp(32'h100);
      chk_outs("alias3", 32'h100, 32'h0, Y, N, 32'h0);
      idle();
      chk_outs("alias4", 32'h100, 32'h0, Y, Y, 32'h100);
      fill(32'h0B0B_0100);
      chk_outs("alias5", 32'h100, 32'h0B0B_0100, N, N, 32'h0);

      // PC wraps past the top of the address space.
      jmp(32'hFFFF_FFFC);
      chk_outs("wrap0", 32'hFFFF_FFFC, 32'h0, Y, N, 32'h0);
      idle();
      chk_outs("wrap1", 32'hFFFF_FFFC, 32'h0, Y, Y, 32'hFFFF_FFFC);
      fill(32'hDEAD_BEEF);
      chk_outs("wrap2", 32'hFFFF_FFFC, 32'hDEAD_BEEF, N, N, 32'h0);
      idle();
      chk_outs("wrap3", 32'h0, 32'h0, Y, N, 32'h0);

      // Asynchronous reset in the middle of a refill.
      jmp(32'h344);
      idle();
      chk_outs("rst0", 32'h344, 32'h0, Y, Y, 32'h344);
      #2 reset = 1'b1;
      #1;
      chk_outs("rst1", 32'h0, 32'h0, Y, N, 32'h0);
      chk("rst1 if_mem_addr", if_mem_addr, 32'h0);
      @(posedge clock);
      #1 reset = 1'b0;
      chk_outs("rst2", 32'h0, 32'h0, Y, N, 32'h0);
      jmp(32'h10);
      chk_outs("rst3", 32'h10, 32'h0, Y, N, 32'h0);
      idle();
      chk_outs("rst4", 32'h10, 32'h0, Y, Y, 32'h10);
      fill(32'h0A0A_0010);

      do_reset();
      random_run(3000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
